// File: rtl/bcd_conv_arbiter.sv
// rtl/bcd_conv_arbiter.sv - round-robin arbiter sharing one BCD-to-binary converter
//
// Purpose: grants one of NREQ requesters, captures its BCD operand, launches the
// shared converter with a start/ready handshake, waits for done (bounded by
// TIMEOUT cycles) and returns the result tagged with the requester index.
//
// Ports:
//   clk_i          clock, rising edge
//   reset_i        asynchronous active-high reset
//   req_i          per-requester pending level, held until acked
//   bcd_i          operand of requester i at [i*N +: N]
//   ack_o          one-hot one-cycle pulse: operand of requester i captured
//   rsp_valid_o    one-cycle response pulse
//   rsp_id_o       requester index of the response (held)
//   rsp_data_o     converted result, 0 on error (held)
//   rsp_err_o      timeout flag qualifying rsp_valid_o (held)
//   busy_o         high whenever the FSM is not idle
//   conv_ready_i   converter can accept a start
//   conv_start_o   converter start (launch state and ready)
//   conv_bcd_o     captured operand presented to the converter
//   conv_done_i    converter done pulse, result valid the same cycle
//   conv_result_i  converter binary result
module bcd_conv_arbiter #(
  parameter int NREQ    = 4,
  parameter int N       = 16,
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*N-1:0]       bcd_i,
  output logic [NREQ-1:0]         ack_o,
  output logic                    rsp_valid_o,
  output logic [$clog2(NREQ)-1:0] rsp_id_o,
  output logic [W-1:0]            rsp_data_o,
  output logic                    rsp_err_o,
  output logic                    busy_o,
  input  logic                    conv_ready_i,
  output logic                    conv_start_o,
  output logic [N-1:0]            conv_bcd_o,
  input  logic                    conv_done_i,
  input  logic [W-1:0]            conv_result_i
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   id_q, id_d;
  logic [N-1:0]    op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]   rsp_id_q, rsp_id_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  logic            gnt_found;
  logic [IW-1:0]   gnt_idx;
  logic [IW:0]     gnt_sum;
  logic [N-1:0]    op_sel;

  // Search upward from ptr+1, wrapping; offset NREQ revisits ptr itself last.
  // gnt_sum is one bit wider so ptr+off (at most 2*NREQ-1) never overflows.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_sum   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      gnt_sum = {1'b0, ptr_q} + (IW+1)'(off);
      if (gnt_sum >= (IW+1)'(NREQ)) begin
        gnt_sum = gnt_sum - (IW+1)'(NREQ);
      end
      if (!gnt_found && req_i[gnt_sum[IW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = gnt_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    op_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == gnt_idx) begin
        op_sel = bcd_i[i*N +: N];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          op_d           = op_sel;
          id_d           = gnt_idx;
          ptr_d          = gnt_idx;
          // Registered so the ack lands in the first LAUNCH cycle only.
          ack_d[gnt_idx] = 1'b1;
          state_d        = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (conv_ready_i) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // done takes priority over a coincident timeout
        if (conv_done_i) begin
          rsp_data_d  = conv_result_i;
          rsp_err_d   = 1'b0;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= IW'(NREQ - 1);
      id_q        <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      ack_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign ack_o        = ack_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_err_o    = rsp_err_q;
  assign busy_o       = (state_q != S_IDLE);
  assign conv_start_o = (state_q == S_LAUNCH) && conv_ready_i;
  assign conv_bcd_o   = op_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb/tb_bcd_conv_arbiter.sv - self-checking bench for bcd_conv_arbiter
module tb_bcd_conv_arbiter;
  localparam int NREQ    = 4;
  localparam int N       = 16;
  localparam int W       = 32;
  localparam int TIMEOUT = 64;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [NREQ-1:0]   req_i;
  logic [NREQ*N-1:0] bcd_i;
  logic [NREQ-1:0]   ack_o;
  logic              rsp_valid_o;
  logic [1:0]        rsp_id_o;
  logic [W-1:0]      rsp_data_o;
  logic              rsp_err_o;
  logic              busy_o;
  logic              conv_ready_i;
  logic              conv_start_o;
  logic [N-1:0]      conv_bcd_o;
  logic              conv_done_i;
  logic [W-1:0]      conv_result_i;

  bcd_conv_arbiter #(.NREQ(NREQ), .N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .bcd_i(bcd_i),
    .ack_o(ack_o), .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
    .conv_ready_i(conv_ready_i), .conv_start_o(conv_start_o),
    .conv_bcd_o(conv_bcd_o), .conv_done_i(conv_done_i),
    .conv_result_i(conv_result_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Converter model: done arrives lat cycles after the start cycle.
  int          lat_cfg;
  bit          never_cfg;
  int          cd;
  logic [15:0] held;
  logic        model_done;
  logic        stray_done;
  logic [31:0] model_result;
  logic [3:0]  pending;

  assign conv_done_i   = model_done | stray_done;
  assign conv_result_i = model_result;

  function automatic logic [31:0] bcd2bin(input logic [15:0] b);
    int v;
    v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + int'(b[i*4 +: 4]);
    return 32'(v);
  endfunction

  always @(negedge clk_i) begin
    model_done   = 1'b0;
    model_result = 32'hDEAD_BEEF;
    if (reset_i) begin
      cd = 0;
    end else begin
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) begin
          model_done   = 1'b1;
          model_result = bcd2bin(held);
        end
      end
      if (conv_start_o && !never_cfg) begin
        cd   = lat_cfg;
        held = conv_bcd_o;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ack(input string nm, output bit ok);
    int k;
    ok = 0;
    k  = 0;
    while (!ok && k < 10) begin
      step();
      k++;
      if (ack_o != 0) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: no ack within 10 cycles", nm);
    end
  endtask

  task automatic wait_rsp(input string nm, input int start_k, output int k, output bit ok);
    k = start_k;
    while (!rsp_valid_o && k < 200) begin
      step();
      k++;
    end
    ok = rsp_valid_o;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: no response within 200 cycles", nm);
    end
  endtask

  task automatic run_txn(input logic [3:0] add, input logic [63:0] bcd, input int lat,
                         input bit never, input int exp_id, input logic [31:0] exp_data,
                         input bit exp_err, input int exp_dly, input string nm);
    bit ok;
    int k;
    lat_cfg   = lat;
    never_cfg = never;
    bcd_i     = bcd;
    pending   = pending | add;
    req_i     = pending;
    wait_ack(nm, ok);
    if (!ok) return;
    chk({nm, " ack"}, 64'(ack_o), 64'(4'b0001 << exp_id));
    chk({nm, " operand"}, 64'(conv_bcd_o), 64'(bcd[exp_id*16 +: 16]));
    chk({nm, " start"}, 64'(conv_start_o), 64'd1);
    pending = pending & ~ack_o;
    req_i   = pending;
    step();
    chk({nm, " ack pulse"}, 64'(ack_o), 64'd0);
    wait_rsp(nm, 1, k, ok);
    if (!ok) return;
    chk({nm, " latency"}, 64'(k), 64'(exp_dly));
    chk({nm, " id"}, 64'(rsp_id_o), 64'(exp_id));
    chk({nm, " data"}, 64'(rsp_data_o), 64'(exp_data));
    chk({nm, " err"}, 64'(rsp_err_o), 64'(exp_err));
    step();
    chk({nm, " valid drop"}, 64'(rsp_valid_o), 64'd0);
    chk({nm, " idle"}, 64'(busy_o), 64'd0);
    chk({nm, " data hold"}, 64'(rsp_data_o), 64'(exp_data));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " ack"}, 64'(ack_o), 64'd0);
    chk({nm, " valid"}, 64'(rsp_valid_o), 64'd0);
    chk({nm, " id"}, 64'(rsp_id_o), 64'd0);
    chk({nm, " data"}, 64'(rsp_data_o), 64'd0);
    chk({nm, " err"}, 64'(rsp_err_o), 64'd0);
    chk({nm, " busy"}, 64'(busy_o), 64'd0);
    chk({nm, " start"}, 64'(conv_start_o), 64'd0);
    chk({nm, " operand"}, 64'(conv_bcd_o), 64'd0);
  endtask

  typedef struct {
    logic [3:0]  add;
    logic [63:0] bcd;
    int          lat;
    bit          never;
    int          id;
    logic [31:0] data;
    bit          err;
    int          dly;
  } vec_t;

  vec_t tbl[10];

  initial begin
    bit ok;
    int k;

    tbl[0] = '{4'b1111, 64'h1000_0100_0010_0001, 5,  1'b0, 0, 32'd1,      1'b0, 6};
    tbl[1] = '{4'b0000, 64'h1000_0100_0010_0001, 5,  1'b0, 1, 32'd10,     1'b0, 6};
    tbl[2] = '{4'b0000, 64'h1000_0100_0010_0001, 5,  1'b0, 2, 32'd100,    1'b0, 6};
    tbl[3] = '{4'b0000, 64'h1000_0100_0010_0001, 3,  1'b0, 3, 32'd1000,   1'b0, 4};
    tbl[4] = '{4'b0001, 64'h0000_0000_0000_1234, 34, 1'b0, 0, 32'h0000_04D2, 1'b0, 35};
    tbl[5] = '{4'b0100, 64'h0000_9999_0000_0000, 1,  1'b0, 2, 32'h0000_270F, 1'b0, 2};
    tbl[6] = '{4'b1001, 64'h0500_0000_0000_0007, 2,  1'b0, 3, 32'h0000_01F4, 1'b0, 3};
    tbl[7] = '{4'b0000, 64'h0500_0000_0000_0007, 2,  1'b0, 0, 32'd7,      1'b0, 3};
    tbl[8] = '{4'b0100, 64'h0000_0777_0000_0000, 0,  1'b1, 2, 32'd0,      1'b1, 65};
    tbl[9] = '{4'b0010, 64'h0000_0000_4321_0000, 64, 1'b0, 1, 32'h0000_10E1, 1'b0, 65};

    reset_i      = 1'b1;
    req_i        = '0;
    bcd_i        = '0;
    pending      = '0;
    conv_ready_i = 1'b1;
    stray_done   = 1'b0;
    lat_cfg      = 1;
    never_cfg    = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    reset_i = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].add, tbl[i].bcd, tbl[i].lat, tbl[i].never, tbl[i].id,
              tbl[i].data, tbl[i].err, tbl[i].dly, $sformatf("vec%0d", i));
    end

    // Converter not ready for 20 cycles after the grant.
    conv_ready_i = 1'b0;
    lat_cfg      = 3;
    never_cfg    = 1'b0;
    bcd_i        = 64'h0000_0000_0042_0000;
    req_i        = 4'b0010;
    wait_ack("stall", ok);
    if (ok) begin
      chk("stall ack", 64'(ack_o), 64'h2);
      req_i = '0;
      for (int i = 0; i < 20; i++) begin
        chk($sformatf("stall start c%0d", i), 64'(conv_start_o), 64'd0);
        chk($sformatf("stall busy c%0d", i), 64'(busy_o), 64'd1);
        chk($sformatf("stall valid c%0d", i), 64'(rsp_valid_o), 64'd0);
        step();
      end
      conv_ready_i = 1'b1;
      #1;
      chk("stall start on ready", 64'(conv_start_o), 64'd1);
      wait_rsp("stall", 0, k, ok);
      if (ok) begin
        chk("stall latency", 64'(k), 64'd4);
        chk("stall id", 64'(rsp_id_o), 64'd1);
        chk("stall data", 64'(rsp_data_o), 64'h2A);
        chk("stall err", 64'(rsp_err_o), 64'd0);
      end
      step();
    end

    // Timeout, then a stray done in IDLE, then a normal conversion.
    run_txn(4'b0100, 64'h0000_0123_0000_0000, 0, 1'b1, 2, 32'd0, 1'b1, 65, "tmo2");
    never_cfg  = 1'b0;
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    chk("stray valid", 64'(rsp_valid_o), 64'd0);
    chk("stray busy", 64'(busy_o), 64'd0);
    step();
    chk("stray valid2", 64'(rsp_valid_o), 64'd0);
    chk("stray err hold", 64'(rsp_err_o), 64'd1);
    run_txn(4'b1000, 64'h0088_0000_0000_0000, 2, 1'b0, 3, 32'h58, 1'b0, 3, "after_tmo");

    // Reset in the middle of WAIT.
    lat_cfg = 50;
    bcd_i   = 64'h0000_0000_0000_0055;
    req_i   = 4'b0001;
    wait_ack("rst", ok);
    req_i   = '0;
    pending = '0;
    for (int i = 0; i < 10; i++) step();
    chk("pre-reset busy", 64'(busy_o), 64'd1);
    reset_i = 1'b1;
    #1;
    chk_all_zero("midreset");
    step();
    step();
    reset_i = 1'b0;
    step();
    run_txn(4'b0101, 64'h0000_0002_0000_0003, 4, 1'b0, 0, 32'd3, 1'b0, 5, "rst_g0");
    run_txn(4'b0000, 64'h0000_0002_0000_0003, 4, 1'b0, 2, 32'd2, 1'b0, 5, "rst_g2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
